lcd_stream_tx: RTL

- Transmit side of the LCD frame link: replays one display frame into an LCD receiver port.
- Sequence per frame: one command byte with lcd_frame low, then FRAME_LEN data bytes with lcd_frame high, each captured by the receiver on a lcd_sync rising edge.
- Bytes are fetched from a local frame-buffer read port. After the last byte the block waits for the receiver's lcd_rdy acknowledge.
- Used by bench/loopback builds and by a host-side board that drives the display stream.

---
 rtl/lcd_stream_tx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_stream_tx.sv
// lcd_stream_tx: replays one frame from a local frame-buffer read port into an
// LCD receiver. One command byte (lcd_frame low) is followed by FRAME_LEN data
// bytes (lcd_frame high), each latched by the receiver on a lcd_sync rising
// edge. The block then waits for the receiver's lcd_rdy acknowledge.
module lcd_stream_tx #(
  parameter int         FRAME_LEN   = 2048,
  parameter int         ADDR_W      = 12,
  parameter logic [7:0] CMD_BYTE    = 8'd132,
  parameter int         SYNC_DIV    = 4,
  parameter int         RDY_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic              lcd_sync,
  output logic              lcd_frame,
  output logic              lcd_en,
  output logic [7:0]        lcd_data,
  output logic              lcd_res1,
  output logic              lcd_res2,
  input  logic              lcd_rdy
);

  localparam int PH_W = (SYNC_DIV > 1) ? $clog2(2 * SYNC_DIV) : 1;
  localparam int TM_W = $clog2(RDY_TIMEOUT + 1);

  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(2 * SYNC_DIV - 1);
  localparam logic [PH_W-1:0]   PH_HIGH  = PH_W'(SYNC_DIV);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [TM_W-1:0]   TM_LAST  = TM_W'(RDY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    FETCH,
    SEND,
    WAIT_RDY
  } state_t;

  state_t            state, state_n;
  logic [PH_W-1:0]   ph, ph_n, ph_inc;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [TM_W-1:0]   timer, timer_n;
  logic              rdy_meta, rdy_sync;

  logic              busy_n, done_n, error_n, rd_n;
  logic [ADDR_W-1:0] addr_n;
  logic              sync_n, frame_n, en_n;
  logic [7:0]        data_n;

  assign lcd_res1 = 1'b0;
  assign lcd_res2 = 1'b0;
  assign ph_inc   = ph + 1'b1;

  // Two-flop synchronizer for the asynchronous receiver acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
    end else begin
      rdy_meta <= lcd_rdy;
      rdy_sync <= rdy_meta;
    end
  end

  // State, counters and every externally visible output are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ph        <= '0;
      cnt       <= '0;
      timer     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      src_rd    <= 1'b0;
      src_addr  <= '0;
      lcd_sync  <= 1'b0;
      lcd_frame <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_data  <= '0;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      cnt       <= cnt_n;
      timer     <= timer_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      src_rd    <= rd_n;
      src_addr  <= addr_n;
      lcd_sync  <= sync_n;
      lcd_frame <= frame_n;
      lcd_en    <= en_n;
      lcd_data  <= data_n;
    end
  end

  // Next-state logic; outputs are computed for the state being entered so
  // that the registered pins line up with the state they belong to
  always_comb begin
    state_n = state;
    ph_n    = ph;
    cnt_n   = cnt;
    timer_n = timer;
    busy_n  = busy;
    done_n  = 1'b0;
    error_n = error;
    rd_n    = 1'b0;
    addr_n  = src_addr;
    sync_n  = lcd_sync;
    frame_n = lcd_frame;
    en_n    = lcd_en;
    data_n  = lcd_data;

    case (state)
      IDLE: begin
        sync_n  = 1'b0;
        frame_n = 1'b0;
        en_n    = 1'b0;
        data_n  = '0;
        busy_n  = 1'b0;
        if (start) begin
          state_n = CMD;
          ph_n    = '0;
          error_n = 1'b0;
          busy_n  = 1'b1;
          en_n    = 1'b1;
          data_n  = CMD_BYTE;
        end
      end

      CMD: begin
        if (ph == PH_LAST) begin
          state_n = FETCH;
          cnt_n   = '0;
          frame_n = 1'b1;
          en_n    = 1'b0;
          sync_n  = 1'b0;
          rd_n    = 1'b1;
          addr_n  = '0;
        end else begin
          ph_n   = ph_inc;
          sync_n = (ph_inc >= PH_HIGH);
        end
      end

      // Read data is captured on the edge closing the fetch cycle, so the
      // byte is on the bus for the whole low half of the following strobe
      FETCH: begin
        state_n = SEND;
        ph_n    = '0;
        sync_n  = 1'b0;
        data_n  = src_data;
      end

      SEND: begin
        if (ph == PH_LAST) begin
          sync_n = 1'b0;
          if (cnt == CNT_LAST) begin
            state_n = WAIT_RDY;
            timer_n = '0;
            frame_n = 1'b0;
            data_n  = '0;
          end else begin
            state_n = FETCH;
            cnt_n   = cnt + 1'b1;
            rd_n    = 1'b1;
            addr_n  = cnt + 1'b1;
          end
        end else begin
          ph_n   = ph_inc;
          sync_n = (ph_inc >= PH_HIGH);
        end
      end

      // Acknowledge is tested before the timeout so a coincident rdy wins
      WAIT_RDY: begin
        if (rdy_sync) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (timer == TM_LAST) begin
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
